apb5_requester: RTL and testbench
=================================

Name: apb5_requester

Overview:
APB5 (rev D) requester. Converts a simple valid/ready command channel into single APB5 transfers on the requester (master) side of the APB5 interface, including pwakeup sequencing and user signals. It returns each completion on a valid/ready response channel. A wait-state timeout prevents a hung completer from stalling the system. It sits between an internal controller or bus bridge and an APB5 completer or decoder.

Parameters:
ADDR_WIDTH, 32, paddr/cmd_addr width
DATA_WIDTH, 32, pwdata/prdata width; must be 8, 16 or 32
USER_REQ_WIDTH, 32, pauser width
USER_DATA_WIDTH, 32, pwuser/pruser width
USER_RESP_WIDTH, 32, pbuser width
WAKEUP_CYCLES, 1, cycles pwakeup is high before pselx when waking from idle; minimum 1
TIMEOUT_CYCLES, 256, number of ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
pclk  in  1  clock
presetn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  write strobes
cmd_prot  in  3  protection (bit0 priv, bit1 non-secure, bit2 instr)
cmd_auser  in  USER_REQ_WIDTH  request user
cmd_wuser  in  USER_DATA_WIDTH  write-data user
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data
rsp_err  out  1  pslverr or timeout
rsp_timeout  out  1  transfer aborted by timeout
rsp_ruser  out  USER_DATA_WIDTH  read-data user
rsp_buser  out  USER_RESP_WIDTH  response user
paddr, pprot, pselx, penable, pwrite, pwdata, pstrb, pwakeup, pauser, pwuser  out  (APB5 widths)  APB5 request signals
pready, prdata, pslverr, pruser, pbuser  in  (APB5 widths)  APB5 completion signals

Behaviour:
- Reset state:
  - all APB outputs are 0 and rsp_* are 0.
  - state is IDLE, cmd_ready = 1 (cmd_ready = state==IDLE, combinational), timeout counter is 0.
- Reset asserted mid-transfer: everything clears immediately; any in-flight response is discarded.
- All APB outputs and rsp_* are registered.
- IDLE:
  - each cycle, pwakeup <= cmd_valid.
  - on accept, capture all cmd_* fields.
  - if pwakeup is already 1, go to SETUP; otherwise go to WAKE.
- WAKE: pwakeup = 1 for WAKEUP_CYCLES cycles, then SETUP.
- SETUP (one cycle): pselx = 1, penable = 0.
  - paddr, pprot, pwrite, pauser are driven from the captured command.
  - writes: pwdata = wdata, pstrb = strb, pwuser = wuser.
  - reads: pwdata = 0, pstrb = 0, pwuser = 0.
  - all of these stay stable until the transfer ends.
- ACCESS: pselx = 1, penable = 1.
  - on pready = 1, capture the response:
    - reads: prdata and pruser.
    - writes: rdata and ruser are forced to 0.
    - both: pslverr and pbuser.
  - next cycle: go to RESP with pselx = penable = 0.
  - each ACCESS cycle with pready = 0 increments the counter.
  - when the counter reaches TIMEOUT_CYCLES (if nonzero), go to RESP with rsp_err = 1, rsp_timeout = 1, rdata/ruser/buser = 0, and drop pselx/penable.
  - a pready arriving in the same cycle as the limit wins and is treated as a normal completion.
- RESP:
  - rsp_valid stays 1 and rsp_* stay stable until rsp_ready is seen; then go to IDLE.
  - rsp_valid deasserts in the IDLE cycle.
  - pwakeup stays 1.
  - the counter clears on leaving ACCESS.
- pwakeup is 1 in WAKE/SETUP/ACCESS/RESP. In IDLE it follows cmd_valid with one-cycle lag, so a back-to-back command skips WAKE.
- Idle values: after a transfer, paddr/pwrite/pprot/pauser hold their last value; pselx = penable = 0.
- Minimum throughput: one transfer per 4 cycles (IDLE accept, SETUP, ACCESS, RESP) when pwakeup is held.
- Only one transfer is outstanding at a time; no buffering beyond the single captured command.

Decomposition:
- Package apb5_pkg:
  - state enum (IDLE, WAKE, SETUP, ACCESS, RESP).
  - PPROT bit index constants (PPROT_PRIV = 0, PPROT_NSEC = 1, PPROT_INSTR = 2).
  - request/response struct typedefs parameterised by widths via localparams.
- One sub-module, apb5_wait_timer: a saturating counter with clear, enable and a limit==0 disable; it outputs expired.

Test Plan:
- Single write (addr 0x0000_0010, wdata 0xDEAD_BEEF, strb 0xF, prot 3'b010) from idle with WAKEUP_CYCLES = 2 -> pwakeup high 2 cycles before pselx; SETUP then ACCESS. Completer pready on first ACCESS cycle -> rsp_valid with rsp_err = 0, rsp_rdata = 0.
- Read of 0x0000_0020, completer inserts 3 wait states then returns prdata = 0x1234_5678 and pruser = 0xA5 -> pstrb = 0 and pwdata = 0 throughout. Exactly 4 ACCESS cycles; rsp_rdata = 0x1234_5678, rsp_ruser = 0xA5.
- Back-to-back commands with cmd_valid held high -> the second transfer skips WAKE. pwakeup stays high continuously; pselx is low for exactly 2 cycles between transfers.
- pslverr = 1 with pbuser = 0x3 on a write -> rsp_err = 1, rsp_timeout = 0, rsp_buser = 0x3.
- TIMEOUT_CYCLES = 8 with pready held low -> pselx/penable drop after 8 ACCESS cycles; rsp_err = 1, rsp_timeout = 1. A case with pready rising on cycle 8 -> normal completion.
- presetn pulsed low during ACCESS -> all outputs 0 immediately; cmd_ready = 1 after release; no rsp_valid ever issued for the aborted command.

Source files
------------

// File: rtl/apb5_pkg.sv
// Shared types and constants for the APB5 requester: FSM states, PPROT bit
// positions and default-width request/response bundles.
package apb5_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAKE,
    SETUP,
    ACCESS,
    RESP
  } apb5_state_e;

  localparam int unsigned PPROT_PRIV  = 0;
  localparam int unsigned PPROT_NSEC  = 1;
  localparam int unsigned PPROT_INSTR = 2;

  localparam int unsigned APB5_ADDR_W  = 32;
  localparam int unsigned APB5_DATA_W  = 32;
  localparam int unsigned APB5_UREQ_W  = 32;
  localparam int unsigned APB5_UDATA_W = 32;
  localparam int unsigned APB5_URESP_W = 32;

  typedef struct packed {
    logic                      write;
    logic [APB5_ADDR_W-1:0]    addr;
    logic [APB5_DATA_W-1:0]    wdata;
    logic [APB5_DATA_W/8-1:0]  strb;
    logic [2:0]                prot;
    logic [APB5_UREQ_W-1:0]    auser;
    logic [APB5_UDATA_W-1:0]   wuser;
  } apb5_req_t;

  typedef struct packed {
    logic [APB5_DATA_W-1:0]    rdata;
    logic                      err;
    logic                      timeout;
    logic [APB5_UDATA_W-1:0]   ruser;
    logic [APB5_URESP_W-1:0]   buser;
  } apb5_rsp_t;

endpackage

// File: rtl/apb5_wait_timer.sv
// Saturating wait-state counter. expired is high in the enabled cycle that
// brings the count up to LIMIT; LIMIT == 0 never expires.
module apb5_wait_timer #(
  parameter int unsigned LIMIT = 256
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != CW'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (LIMIT != 0) && en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/apb5_requester.sv
// APB5 requester: turns a valid/ready command into one APB5 transfer with
// pwakeup sequencing and a wait-state timeout, returning a registered response.
module apb5_requester
  import apb5_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = APB5_ADDR_W,
  parameter int unsigned DATA_WIDTH      = APB5_DATA_W,
  parameter int unsigned USER_REQ_WIDTH  = APB5_UREQ_W,
  parameter int unsigned USER_DATA_WIDTH = APB5_UDATA_W,
  parameter int unsigned USER_RESP_WIDTH = APB5_URESP_W,
  parameter int unsigned WAKEUP_CYCLES   = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [DATA_WIDTH-1:0]      cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]    cmd_strb,
  input  logic [2:0]                 cmd_prot,
  input  logic [USER_REQ_WIDTH-1:0]  cmd_auser,
  input  logic [USER_DATA_WIDTH-1:0] cmd_wuser,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       rsp_err,
  output logic                       rsp_timeout,
  output logic [USER_DATA_WIDTH-1:0] rsp_ruser,
  output logic [USER_RESP_WIDTH-1:0] rsp_buser,
  output logic [ADDR_WIDTH-1:0]      paddr,
  output logic [2:0]                 pprot,
  output logic                       pselx,
  output logic                       penable,
  output logic                       pwrite,
  output logic [DATA_WIDTH-1:0]      pwdata,
  output logic [DATA_WIDTH/8-1:0]    pstrb,
  output logic                       pwakeup,
  output logic [USER_REQ_WIDTH-1:0]  pauser,
  output logic [USER_DATA_WIDTH-1:0] pwuser,
  input  logic                       pready,
  input  logic [DATA_WIDTH-1:0]      prdata,
  input  logic                       pslverr,
  input  logic [USER_DATA_WIDTH-1:0] pruser,
  input  logic [USER_RESP_WIDTH-1:0] pbuser
);

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_dw
    $error("apb5_requester: DATA_WIDTH must be 8, 16 or 32");
  end
  if (WAKEUP_CYCLES < 1) begin : g_bad_wake
    $error("apb5_requester: WAKEUP_CYCLES must be at least 1");
  end

  localparam int unsigned WW = (WAKEUP_CYCLES < 2) ? 1 : $clog2(WAKEUP_CYCLES);

  typedef struct packed {
    logic                       write;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [DATA_WIDTH/8-1:0]    strb;
    logic [2:0]                 prot;
    logic [USER_REQ_WIDTH-1:0]  auser;
    logic [USER_DATA_WIDTH-1:0] wuser;
  } req_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]      rdata;
    logic                       err;
    logic                       timeout;
    logic [USER_DATA_WIDTH-1:0] ruser;
    logic [USER_RESP_WIDTH-1:0] buser;
  } rsp_t;

  apb5_state_e   state, state_d;
  logic [WW-1:0] wake_cnt;
  req_t          cmd_in, req_q, src, drv_q, drv_d;
  rsp_t          rsp_q, rsp_d;
  logic          sel_q, sel_d, en_q, en_d, wake_q, wake_d, rvalid_q, rvalid_d;
  logic          accept, wake_done, tmo;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign wake_done = (wake_cnt == WW'(WAKEUP_CYCLES - 1));
  assign cmd_in    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, strb: cmd_strb,
                       prot: cmd_prot, auser: cmd_auser, wuser: cmd_wuser};
  // Going straight IDLE->SETUP the capture register is not loaded yet, so use the live command.
  assign src       = (state == IDLE) ? cmd_in : req_q;

  apb5_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
    .pclk    (pclk),
    .presetn (presetn),
    .clr     (state != ACCESS),
    .en      ((state == ACCESS) && !pready),
    .expired (tmo)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state    <= IDLE;
      wake_cnt <= '0;
      req_q    <= '0;
      drv_q    <= '0;
      rsp_q    <= '0;
      sel_q    <= 1'b0;
      en_q     <= 1'b0;
      wake_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state    <= state_d;
      wake_cnt <= (state == WAKE) ? wake_cnt + 1'b1 : '0;
      if (accept) req_q <= cmd_in;
      drv_q    <= drv_d;
      rsp_q    <= rsp_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      wake_q   <= wake_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept) state_d = pwakeup ? SETUP : WAKE;
      WAKE:    if (wake_done) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || tmo) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drv_d    = drv_q;
    rsp_d    = rsp_q;
    sel_d    = (state_d == SETUP) || (state_d == ACCESS);
    en_d     = (state_d == ACCESS);
    wake_d   = (state == IDLE) ? cmd_valid : 1'b1;
    rvalid_d = (state_d == RESP);
    if ((state_d == SETUP) && (state != SETUP)) begin
      drv_d.write = src.write;
      drv_d.addr  = src.addr;
      drv_d.prot  = src.prot;
      drv_d.auser = src.auser;
      drv_d.wdata = src.write ? src.wdata : '0;
      drv_d.strb  = src.write ? src.strb  : '0;
      drv_d.wuser = src.write ? src.wuser : '0;
    end
    if ((state == ACCESS) && (state_d == RESP)) begin
      rsp_d = '0;
      if (pready) begin
        rsp_d.rdata = drv_q.write ? '0 : prdata;
        rsp_d.ruser = drv_q.write ? '0 : pruser;
        rsp_d.err   = pslverr;
        rsp_d.buser = pbuser;
      end else begin
        rsp_d.err     = 1'b1;
        rsp_d.timeout = 1'b1;
      end
    end
  end

  assign paddr       = drv_q.addr;
  assign pprot       = drv_q.prot;
  assign pwrite      = drv_q.write;
  assign pwdata      = drv_q.wdata;
  assign pstrb       = drv_q.strb;
  assign pauser      = drv_q.auser;
  assign pwuser      = drv_q.wuser;
  assign pselx       = sel_q;
  assign penable     = en_q;
  assign pwakeup     = wake_q;
  assign rsp_valid   = rvalid_q;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign rsp_ruser   = rsp_q.ruser;
  assign rsp_buser   = rsp_q.buser;

endmodule

// File: tb/tb_apb5_requester.sv
// Directed bench for apb5_requester (WAKEUP_CYCLES=2, TIMEOUT_CYCLES=8) with
// an inline completer; outputs sampled and inputs driven on the falling edge.
module tb_apb5_requester;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata, cmd_auser, cmd_wuser;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, rsp_ruser, rsp_buser;
  logic [31:0] paddr, pwdata, pauser, pwuser;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;
  logic        pselx, penable, pwrite, pwakeup;
  logic        pready, pslverr;
  logic [31:0] prdata, pruser, pbuser;

  apb5_requester #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_REQ_WIDTH(32), .USER_DATA_WIDTH(32),
    .USER_RESP_WIDTH(32), .WAKEUP_CYCLES(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot), .cmd_auser(cmd_auser),
    .cmd_wuser(cmd_wuser),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .rsp_ruser(rsp_ruser), .rsp_buser(rsp_buser),
    .paddr(paddr), .pprot(pprot), .pselx(pselx), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pwakeup(pwakeup), .pauser(pauser), .pwuser(pwuser),
    .pready(pready), .prdata(prdata), .pslverr(pslverr), .pruser(pruser), .pbuser(pbuser)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // Issues one command (called at a falling edge while the DUT is idle) and
  // plays the completer: pready rises on ACCESS cycle waits+1.
  task automatic xfer(input string nm, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int waits,
                      input logic [31:0] rd, input logic [31:0] ru, input logic perr, input logic [31:0] pbu,
                      input logic keep, input int rsp_delay,
                      input logic exp_err, input logic exp_to, input logic [31:0] exp_rdata,
                      input logic [31:0] exp_ruser, input logic [31:0] exp_buser,
                      input int exp_pre, input int exp_acc);
    int pre = 0, setup = 0, acc = 0, tail = 0, pw_low = 0, bad = 0, rwait = 0;
    logic seen_sel = 1'b0, got_rsp = 1'b0, done = 1'b0;
    logic [31:0] auser, wuser;
    auser = ~addr;
    wuser = {wdata[15:0], wdata[31:16]};
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
    cmd_auser = auser; cmd_wuser = wuser; cmd_valid = 1'b1;
    check({nm, ".cmd_ready"}, cmd_ready, 1);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge pclk);
      cmd_valid = keep;
      if (!pwakeup) pw_low++;
      if (pselx) begin
        seen_sel = 1'b1;
        if (paddr !== addr || pwrite !== wr || pprot !== prot || pauser !== auser ||
            pwdata !== (wr ? wdata : 32'h0) || pstrb !== (wr ? strb : 4'h0) ||
            pwuser !== (wr ? wuser : 32'h0)) bad++;
        if (!penable) setup++;
        else begin
          acc++;
          pready  = (acc > waits);
          prdata  = pready ? rd   : 32'hBAD0_BAD0;
          pruser  = pready ? ru   : 32'h0000_005A;
          pslverr = pready ? perr : 1'b1;
          pbuser  = pready ? pbu  : 32'h0000_0007;
        end
      end else if (!seen_sel) begin
        pre++;
      end else begin
        pready = 1'b0;
        tail++;
        if (rsp_valid) begin
          got_rsp = 1'b1;
          check({nm, ".rsp_err"}, rsp_err, exp_err);
          check({nm, ".rsp_timeout"}, rsp_timeout, exp_to);
          check({nm, ".rsp_rdata"}, rsp_rdata, exp_rdata);
          check({nm, ".rsp_ruser"}, rsp_ruser, exp_ruser);
          check({nm, ".rsp_buser"}, rsp_buser, exp_buser);
          rsp_ready = (rwait >= rsp_delay);
          rwait++;
        end else begin
          rsp_ready = 1'b0;
          done = 1'b1;
        end
      end
    end
    rsp_ready = 1'b0;
    pready    = 1'b0;
    check({nm, ".completed"}, done, 1);
    check({nm, ".got_rsp"}, got_rsp, 1);
    check({nm, ".wake_cycles"}, pre, exp_pre);
    check({nm, ".setup_cycles"}, setup, 1);
    check({nm, ".access_cycles"}, acc, exp_acc);
    check({nm, ".req_stable"}, bad, 0);
    check({nm, ".sel_low_after"}, tail, 2 + rsp_delay);
    check({nm, ".pwakeup_held"}, pw_low, 0);
  endtask

  initial begin
    int cnt;
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; cmd_auser = '0; cmd_wuser = '0; rsp_ready = 1'b0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0; pruser = '0; pbuser = '0;

    @(negedge pclk);
    check("reset.cmd_ready", cmd_ready, 1);
    check("reset.apb", {pselx, penable, pwrite, pwakeup, pprot, pstrb}, 0);
    check("reset.paddr", paddr, 0);
    check("reset.rsp", {rsp_valid, rsp_err, rsp_timeout}, 0);
    check("reset.rsp_rdata", rsp_rdata, 0);
    @(negedge pclk);
    presetn = 1'b1;
    idle(2);
    check("idle.pwakeup", pwakeup, 0);

    xfer("wr1", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 32'h5555_AAAA, 32'h33, 1'b0, 32'h0,
         1'b0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2, 1);
    idle(2);
    check("hold.paddr", paddr, 32'h0000_0010);
    check("hold.pwrite_sel", {pwrite, pselx, penable}, 3'b100);
    check("hold.pwakeup", pwakeup, 0);

    xfer("rd1", 1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 3'b000, 3, 32'h1234_5678, 32'hA5, 1'b0, 32'h1,
         1'b0, 0, 1'b0, 1'b0, 32'h1234_5678, 32'hA5, 32'h1, 2, 4);
    idle(3);

    xfer("b2b_a", 1'b1, 32'h0000_0030, 32'h0000_0030, 4'h3, 3'b001, 0, 32'h0, 32'h0, 1'b0, 32'h0,
         1'b1, 0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2, 1);
    xfer("b2b_b", 1'b0, 32'h0000_0034, 32'h0, 4'h0, 3'b000, 1, 32'hCAFE_0034, 32'h34, 1'b0, 32'h0,
         1'b0, 0, 1'b0, 1'b0, 32'hCAFE_0034, 32'h34, 32'h0, 0, 2);
    idle(3);

    xfer("slverr", 1'b1, 32'h0000_0044, 32'h0102_0304, 4'h5, 3'b100, 0, 32'hFFFF_0000, 32'h77, 1'b1, 32'h3,
         1'b0, 2, 1'b1, 1'b0, 32'h0, 32'h0, 32'h3, 2, 1);
    idle(3);

    xfer("tmo", 1'b0, 32'h0000_0050, 32'h0, 4'h0, 3'b011, 100, 32'h0, 32'h0, 1'b0, 32'h0,
         1'b0, 0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 2, 8);
    idle(3);

    xfer("rdy_at_lim", 1'b0, 32'h0000_0060, 32'h0, 4'h0, 3'b000, 7, 32'h8888_0008, 32'h11, 1'b0, 32'h2,
         1'b0, 0, 1'b0, 1'b0, 32'h8888_0008, 32'h11, 32'h2, 2, 8);
    idle(3);

    // Reset pulse while the completer is stalling in ACCESS.
    cmd_write = 1'b1; cmd_addr = 32'h0000_0070; cmd_wdata = 32'h7777_7777; cmd_strb = 4'hF;
    cmd_prot = 3'b001; cmd_valid = 1'b1;
    cnt = 0;
    while (!(pselx && penable) && cnt < 20) begin
      @(negedge pclk);
      cmd_valid = 1'b0;
      cnt++;
    end
    check("rst.reach_access", (cnt < 20), 1);
    presetn = 1'b0;
    #1;
    check("rst.sel_en", {pselx, penable}, 0);
    check("rst.pwakeup", pwakeup, 0);
    check("rst.paddr", paddr, 0);
    check("rst.pwdata", pwdata, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    @(negedge pclk);
    presetn = 1'b1;
    check("rst.cmd_ready", cmd_ready, 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      if (rsp_valid || pselx) cnt++;
    end
    check("rst.no_rsp", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
